// File: rtl/oob_dev.sv
// oob_dev: SATA device-side out-of-band link bring-up.
// Waits for COMRESET, answers with COMINIT, waits for COMWAKE and answers it,
// transmits ALIGNp until the host ALIGNp is seen, transmits SYNCp until three
// consecutive non-ALIGNp dwords arrive, then hands the transmit path to the user.
// A wait timer aborts a stalled sequence back to IDLE. A COMRESET seen at any
// point restarts the handshake.

module oob_dev #(
  parameter int          DATA_BYTE_WIDTH = 4,
  parameter logic [19:0] TIMER_LIMIT     = 20'd131070
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rxcominitdet_in,
  input  logic                           rxcomwakedet_in,
  input  logic                           rxelecidle_in,
  output logic                           txcominit,
  output logic                           txcomwake,
  output logic                           txelecidle,
  input  logic [DATA_BYTE_WIDTH*8-1:0]   txdata_in,
  input  logic [DATA_BYTE_WIDTH-1:0]     txcharisk_in,
  output logic [DATA_BYTE_WIDTH*8-1:0]   txdata_out,
  output logic [DATA_BYTE_WIDTH-1:0]     txcharisk_out,
  input  logic [DATA_BYTE_WIDTH*8-1:0]   rxdata_in,
  input  logic [DATA_BYTE_WIDTH-1:0]     rxcharisk_in,
  output logic [DATA_BYTE_WIDTH*8-1:0]   rxdata_out,
  output logic [DATA_BYTE_WIDTH-1:0]     rxcharisk_out,
  output logic                           link_up,
  output logic                           link_down,
  output logic                           oob_done,
  output logic                           oob_error
);

  localparam int DW = DATA_BYTE_WIDTH * 8;
  localparam int KW = DATA_BYTE_WIDTH;

  // SATA primitives; both carry a K28 character in byte 0 only.
  localparam logic [DW-1:0] ALIGN_PRIM = 32'h7B4A_4ABC;
  localparam logic [DW-1:0] SYNC_PRIM  = 32'hB5B5_957C;
  localparam logic [KW-1:0] PRIM_K     = 4'h1;

  typedef enum logic [4:0] {
    IDLE         = 5'b00001,
    WAIT_COMWAKE = 5'b00010,
    SEND_ALIGN   = 5'b00100,
    SEND_SYNC    = 5'b01000,
    READY        = 5'b10000
  } state_t;

  // True when a received dword is exactly the ALIGNp primitive.
  function automatic logic is_align(input logic [DW-1:0] data, input logic [KW-1:0] isk);
    return (data == ALIGN_PRIM) && (isk == PRIM_K);
  endfunction

  // Registered receive-side copies.
  logic            cominit_r;
  logic            comwake_r;
  logic            elecidle_r;
  logic [DW-1:0]   rxdata_r;
  logic [KW-1:0]   rxcharisk_r;
  logic            link_down_r;

  // FSM state and bookkeeping.
  state_t          state_r;
  state_t          state_nxt_s;
  logic [19:0]     timer_r;
  logic [1:0]      cnt_r;
  logic            go_wait_s;
  logic            timeout_s;
  logic            timing_s;
  logic            align_s;

  // Registered outputs.
  logic            txcominit_r;
  logic            txcomwake_r;
  logic            txelecidle_r;
  logic            link_up_r;
  logic            oob_done_r;
  logic            oob_error_r;
  logic [DW-1:0]   txdata_r;
  logic [KW-1:0]   txcharisk_r;

  // Capture every receive-side input once; all downstream logic uses these copies.
  always_ff @(posedge clk) begin
    if (rst) begin
      cominit_r   <= 1'b0;
      comwake_r   <= 1'b0;
      elecidle_r  <= 1'b0;
      rxdata_r    <= '0;
      rxcharisk_r <= '0;
    end else begin
      cominit_r   <= rxcominitdet_in;
      comwake_r   <= rxcomwakedet_in;
      elecidle_r  <= rxelecidle_in;
      rxdata_r    <= rxdata_in;
      rxcharisk_r <= rxcharisk_in;
    end
  end

  // Second stage of the line-idle pipeline; this is the link_down level.
  always_ff @(posedge clk) begin
    if (rst) begin
      link_down_r <= 1'b0;
    end else begin
      link_down_r <= elecidle_r;
    end
  end

  assign align_s  = is_align(rxdata_r, rxcharisk_r);
  assign timing_s = (state_r == WAIT_COMWAKE) || (state_r == SEND_ALIGN) ||
                    (state_r == SEND_SYNC);

  // Next-state decision: COMRESET restart beats timeout, timeout beats normal flow.
  always_comb begin
    state_nxt_s = state_r;
    go_wait_s   = 1'b0;
    timeout_s   = 1'b0;
    if (cominit_r) begin
      state_nxt_s = WAIT_COMWAKE;
      go_wait_s   = 1'b1;
    end else if (timing_s && (timer_r == TIMER_LIMIT)) begin
      state_nxt_s = IDLE;
      timeout_s   = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = IDLE;
        end
        WAIT_COMWAKE: begin
          if (comwake_r) begin
            state_nxt_s = SEND_ALIGN;
          end else begin
            state_nxt_s = WAIT_COMWAKE;
          end
        end
        SEND_ALIGN: begin
          if (align_s) begin
            state_nxt_s = SEND_SYNC;
          end else begin
            state_nxt_s = SEND_ALIGN;
          end
        end
        SEND_SYNC: begin
          if (!align_s && (cnt_r == 2'd2)) begin
            state_nxt_s = READY;
          end else begin
            state_nxt_s = SEND_SYNC;
          end
        end
        READY: begin
          if (link_down_r) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = READY;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State register, wait timer, non-ALIGNp counter and all registered FSM outputs.
  // Outputs are computed from the state being entered so they line up with state_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      timer_r      <= 20'd0;
      cnt_r        <= 2'd0;
      txcominit_r  <= 1'b0;
      txcomwake_r  <= 1'b0;
      txelecidle_r <= 1'b1;
      link_up_r    <= 1'b0;
      oob_done_r   <= 1'b0;
      oob_error_r  <= 1'b0;
      txdata_r     <= '0;
      txcharisk_r  <= '0;
    end else begin
      state_r <= state_nxt_s;

      // Timer runs only while waiting on the host; any state change or restart clears it.
      if (go_wait_s || (state_nxt_s != state_r) || !timing_s) begin
        timer_r <= 20'd0;
      end else begin
        timer_r <= timer_r + 20'd1;
      end

      // Count back-to-back non-ALIGNp dwords while staying in SEND_SYNC.
      if ((state_r == SEND_SYNC) && (state_nxt_s == SEND_SYNC)) begin
        if (align_s) begin
          cnt_r <= 2'd0;
        end else begin
          cnt_r <= cnt_r + 2'd1;
        end
      end else begin
        cnt_r <= 2'd0;
      end

      txcominit_r  <= go_wait_s;
      txcomwake_r  <= (state_r == WAIT_COMWAKE) && (state_nxt_s == SEND_ALIGN);
      txelecidle_r <= (state_nxt_s == IDLE) || (state_nxt_s == WAIT_COMWAKE);
      link_up_r    <= (state_nxt_s == READY);
      oob_done_r   <= (state_nxt_s == READY) && (state_r != READY);
      oob_error_r  <= timeout_s;

      case (state_nxt_s)
        SEND_ALIGN: begin
          txdata_r    <= ALIGN_PRIM;
          txcharisk_r <= PRIM_K;
        end
        SEND_SYNC: begin
          txdata_r    <= SYNC_PRIM;
          txcharisk_r <= PRIM_K;
        end
        READY: begin
          txdata_r    <= txdata_in;
          txcharisk_r <= txcharisk_in;
        end
        default: begin
          txdata_r    <= '0;
          txcharisk_r <= '0;
        end
      endcase
    end
  end

  assign txcominit     = txcominit_r;
  assign txcomwake     = txcomwake_r;
  assign txelecidle    = txelecidle_r;
  assign txdata_out    = txdata_r;
  assign txcharisk_out = txcharisk_r;
  assign rxdata_out    = rxdata_r;
  assign rxcharisk_out = rxcharisk_r;
  assign link_up       = link_up_r;
  assign link_down     = link_down_r;
  assign oob_done      = oob_done_r;
  assign oob_error     = oob_error_r;

endmodule

// File: tb/tb_oob_dev.sv
// Bench for oob_dev: stimulus pushes the expected pulse events into a
// scoreboard queue; a monitor thread pops and compares whenever any of
// txcominit/txcomwake/oob_done/oob_error fires. Level outputs get direct checks.

module tb_oob_dev;

  localparam logic [19:0] LIMIT    = 20'd40;
  localparam logic [31:0] ALIGNP   = 32'h7B4A_4ABC;
  localparam logic [31:0] SYNCP    = 32'hB5B5_957C;
  localparam logic [31:0] TXD_USER = 32'hCAFE_F00D;

  // Event record: {cominit, comwake, done, error, txelecidle, link_up, txdata_out}
  typedef logic [37:0] exp_t;
  localparam exp_t EXP_INIT = {4'b1000, 1'b1, 1'b0, 32'h0000_0000};
  localparam exp_t EXP_WAKE = {4'b0100, 1'b0, 1'b0, ALIGNP};
  localparam exp_t EXP_DONE = {4'b0010, 1'b0, 1'b1, TXD_USER};
  localparam exp_t EXP_ERR  = {4'b0001, 1'b1, 1'b0, 32'h0000_0000};

  logic        clk = 1'b0;
  logic        rst;
  logic        rxcominitdet_in, rxcomwakedet_in, rxelecidle_in;
  logic        txcominit, txcomwake, txelecidle;
  logic [31:0] txdata_in, txdata_out, rxdata_in, rxdata_out;
  logic [3:0]  txcharisk_in, txcharisk_out, rxcharisk_in, rxcharisk_out;
  logic        link_up, link_down, oob_done, oob_error;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  oob_dev #(.DATA_BYTE_WIDTH(4), .TIMER_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .rxcominitdet_in(rxcominitdet_in), .rxcomwakedet_in(rxcomwakedet_in),
    .rxelecidle_in(rxelecidle_in),
    .txcominit(txcominit), .txcomwake(txcomwake), .txelecidle(txelecidle),
    .txdata_in(txdata_in), .txcharisk_in(txcharisk_in),
    .txdata_out(txdata_out), .txcharisk_out(txcharisk_out),
    .rxdata_in(rxdata_in), .rxcharisk_in(rxcharisk_in),
    .rxdata_out(rxdata_out), .rxcharisk_out(rxcharisk_out),
    .link_up(link_up), .link_down(link_down),
    .oob_done(oob_done), .oob_error(oob_error)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_cominit();
    rxcominitdet_in = 1'b1;
    step();
    rxcominitdet_in = 1'b0;
  endtask

  task automatic pulse_comwake();
    rxcomwakedet_in = 1'b1;
    step();
    rxcomwakedet_in = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k);
    rxdata_in    = d;
    rxcharisk_in = k;
    step();
  endtask

  task automatic idle_data();
    rxdata_in    = 32'h0000_0000;
    rxcharisk_in = 4'h0;
  endtask

  // COMRESET + COMWAKE handshake; leaves the DUT in SEND_ALIGN.
  task automatic handshake();
    exp_q.push_back(EXP_INIT);
    pulse_cominit();
    step(3);
    exp_q.push_back(EXP_WAKE);
    pulse_comwake();
    step(3);
  endtask

  // One host ALIGNp then three SYNCp; leaves the DUT in READY.
  task automatic align_sync();
    send(ALIGNP, 4'h1);
    exp_q.push_back(EXP_DONE);
    send(SYNCP, 4'h1);
    send(SYNCP, 4'h1);
    send(SYNCP, 4'h1);
    idle_data();
    step(3);
  endtask

  // Drop the link through line idle, back to IDLE.
  task automatic link_drop();
    rxelecidle_in = 1'b1;
    step(4);
    rxelecidle_in = 1'b0;
    step(3);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {57'd0, txcominit, txcomwake, txelecidle, link_up, link_down,
                           oob_done, oob_error}, {57'd0, 7'b0010000});
    check({tag, "_tx"}, {28'd0, txdata_out, txcharisk_out}, 64'd0);
    check({tag, "_rx"}, {28'd0, rxdata_out, rxcharisk_out}, 64'd0);
  endtask

  // Scoreboard monitor: every pulse-type output event must match the queue head.
  task automatic monitor_loop();
    exp_t act;
    exp_t e;
    forever begin
      @(negedge clk);
      if (txcominit || txcomwake || oob_done || oob_error) begin
        act = {txcominit, txcomwake, oob_done, oob_error, txelecidle, link_up, txdata_out};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event: got %h expected no event", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL event: got %h expected %h", act, e);
          end
        end
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    rxcominitdet_in = 1'b0;
    rxcomwakedet_in = 1'b0;
    rxelecidle_in   = 1'b0;
    txdata_in       = TXD_USER;
    txcharisk_in    = 4'h0;
    rxdata_in       = 32'h5555_AAAA;
    rxcharisk_in    = 4'hF;
    fork
      monitor_loop();
      begin
        // Reset values
        step(3);
        check_reset_outputs("reset");
        rst = 1'b0;

        // rx path is a plain 1-cycle register; IDLE transmits zeros
        send(32'h1234_5678, 4'h2);
        check("rx_idle", {28'd0, rxdata_out, rxcharisk_out}, {28'd0, 32'h1234_5678, 4'h2});
        check("tx_idle", {28'd0, txdata_out, txcharisk_out}, 64'd0);

        // COMWAKE and ALIGNp in IDLE are ignored
        pulse_comwake();
        send(ALIGNP, 4'h1);
        idle_data();
        step(3);
        check("ignore_idle", {62'd0, txelecidle, link_up}, {62'd0, 2'b10});

        // Nominal bring-up
        handshake();
        check("align_tx", {28'd0, txdata_out, txcharisk_out}, {28'd0, ALIGNP, 4'h1});
        align_sync();
        check("ready_lvl", {62'd0, link_up, txelecidle}, {62'd0, 2'b10});
        txdata_in    = 32'h0BAD_BEEF;
        txcharisk_in = 4'h3;
        step();
        check("ready_tx", {28'd0, txdata_out, txcharisk_out}, {28'd0, 32'h0BAD_BEEF, 4'h3});
        send(32'hDEAD_BEEF, 4'h8);
        check("rx_ready", {28'd0, rxdata_out, rxcharisk_out}, {28'd0, 32'hDEAD_BEEF, 4'h8});
        idle_data();
        txdata_in    = TXD_USER;
        txcharisk_in = 4'h0;

        // Line idle in READY: link_down after 2 cycles, link_up drops one later
        rxelecidle_in = 1'b1;
        step();
        check("ld_1", {63'd0, link_down}, 64'd0);
        step();
        check("ld_2", {62'd0, link_down, link_up}, {62'd0, 2'b11});
        step();
        check("ld_3", {62'd0, link_up, txelecidle}, {62'd0, 2'b01});
        rxelecidle_in = 1'b0;
        step(3);
        check("q_nominal", 64'(exp_q.size()), 64'd0);

        // ALIGNp in the middle of SYNC resets the run of three
        handshake();
        send(ALIGNP, 4'h1);
        send(SYNCP, 4'h1);
        send(SYNCP, 4'h1);
        send(ALIGNP, 4'h1);
        send(SYNCP, 4'h1);
        send(SYNCP, 4'h1);
        exp_q.push_back(EXP_DONE);
        send(SYNCP, 4'h1);
        idle_data();
        check("sync_5th", {63'd0, link_up}, 64'd0);
        step();
        check("sync_6th", {63'd0, link_up}, 64'd1);
        link_drop();
        check("q_sync", 64'(exp_q.size()), 64'd0);

        // Timeout: no COMWAKE after COMINIT
        exp_q.push_back(EXP_INIT);
        exp_q.push_back(EXP_ERR);
        pulse_cominit();
        step(41);
        check("to_before", {63'd0, oob_error}, 64'd0);
        step();
        check("to_at", {62'd0, oob_error, txelecidle}, {62'd0, 2'b11});
        step();
        check("to_after", {31'd0, oob_error, link_up, txelecidle, txdata_out},
              {31'd0, 3'b001, 32'h0});
        step(3);
        check("q_timeout", 64'(exp_q.size()), 64'd0);

        // COMRESET during SEND_ALIGN restarts, then completes
        handshake();
        exp_q.push_back(EXP_INIT);
        pulse_cominit();
        step();
        check("restart", {30'd0, txcominit, txelecidle, txdata_out}, {30'd0, 2'b11, 32'h0});
        step(2);
        exp_q.push_back(EXP_WAKE);
        pulse_comwake();
        step(3);
        align_sync();
        check("restart_ready", {63'd0, link_up}, 64'd1);
        link_drop();
        check("q_restart", 64'(exp_q.size()), 64'd0);

        // Reset in SEND_SYNC with SYNCp still arriving: reset values, no oob_done
        handshake();
        send(ALIGNP, 4'h1);
        send(SYNCP, 4'h1);
        rst = 1'b1;
        step();
        check_reset_outputs("mid_rst");
        step(2);
        rst = 1'b0;
        step(6);
        check("post_rst", {62'd0, link_up, txelecidle}, {62'd0, 2'b01});
        idle_data();
        step(3);
        check("q_final", 64'(exp_q.size()), 64'd0);
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
